// File: rtl/regfile_write_buffer.sv
// ============================================================================
// Module   : regfile_write_buffer
// Purpose  : In-order write FIFO between writeback and the register file, with
//            two forwarding lookups (enabled by WBUF_FORWARD_EN).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module regfile_write_buffer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     PushValid,
  output logic                     PushReady,
  input  logic [ADDR_W-1:0]        PushAddress,
  input  logic [DATA_W-1:0]        PushData,
  input  logic                     DrainEn,
  output logic [ADDR_W-1:0]        WriteAddress,
  output logic [DATA_W-1:0]        WriteData,
  output logic                     ReadWriteEn,
  input  logic [ADDR_W-1:0]        FwdAddress1,
  input  logic [ADDR_W-1:0]        FwdAddress2,
  output logic                     FwdHit1,
  output logic                     FwdHit2,
  output logic [DATA_W-1:0]        FwdData1,
  output logic [DATA_W-1:0]        FwdData2,
  output logic [$clog2(DEPTH):0]   Count
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;

  logic [ADDR_W-1:0]  r_addrMem [DEPTH];
  logic [DATA_W-1:0]  r_dataMem [DEPTH];
  logic [c_PTR_W-1:0] r_wrPtr;
  logic [c_PTR_W-1:0] r_rdPtr;
  logic [c_CNT_W-1:0] r_count;

  logic w_full;
  logic w_empty;
  logic w_store;
  logic w_pop;

  assign w_full      = (r_count == c_CNT_W'(DEPTH));
  assign w_empty     = (r_count == '0);
  assign PushReady   = !w_full;
  assign ReadWriteEn = !w_empty && DrainEn;
  assign Count       = r_count;

  // Writes to register 0 complete the handshake but are dropped here.
  assign w_store = PushValid && PushReady && (PushAddress != '0);
  assign w_pop   = ReadWriteEn;

  assign WriteAddress = w_empty ? '0 : r_addrMem[r_rdPtr];
  assign WriteData    = w_empty ? '0 : r_dataMem[r_rdPtr];

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_store) r_wrPtr <= r_wrPtr + c_PTR_W'(1);
      if (w_pop)   r_rdPtr <= r_rdPtr + c_PTR_W'(1);
      case ({w_store, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage needs no reset; occupancy alone defines which slots are live.
  always_ff @(posedge CLK) begin
    if (w_store && !RST) begin
      r_addrMem[r_wrPtr] <= PushAddress;
      r_dataMem[r_wrPtr] <= PushData;
    end
  end

`ifdef WBUF_FORWARD_EN
  logic [ADDR_W-1:0] w_fwdAddr [2];
  logic              w_fwdHit  [2];
  logic [DATA_W-1:0] w_fwdData [2];

  assign w_fwdAddr[0] = FwdAddress1;
  assign w_fwdAddr[1] = FwdAddress2;

  generate
    for (genvar p = 0; p < 2; p++) begin : g_fwdPort
      // Walk oldest to newest so the newest match overwrites older ones.
      always_comb begin
        logic [c_PTR_W-1:0] idx;
        w_fwdHit[p]  = 1'b0;
        w_fwdData[p] = '0;
        idx          = '0;
        for (int k = 0; k < DEPTH; k++) begin
          idx = r_rdPtr + c_PTR_W'(k);
          if ((c_CNT_W'(k) < r_count) && (w_fwdAddr[p] != '0) &&
              (r_addrMem[idx] == w_fwdAddr[p])) begin
            w_fwdHit[p]  = 1'b1;
            w_fwdData[p] = r_dataMem[idx];
          end
        end
      end
    end
  endgenerate

  assign FwdHit1  = w_fwdHit[0];
  assign FwdHit2  = w_fwdHit[1];
  assign FwdData1 = w_fwdData[0];
  assign FwdData2 = w_fwdData[1];
`else
  logic w_unusedFwdAddr;
  assign w_unusedFwdAddr = ^{FwdAddress1, FwdAddress2};

  assign FwdHit1  = 1'b0;
  assign FwdHit2  = 1'b0;
  assign FwdData1 = '0;
  assign FwdData2 = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_regfile_write_buffer.sv
// ============================================================================
// Module   : tb_regfile_write_buffer
// Purpose  : Directed self-checking bench for regfile_write_buffer.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_regfile_write_buffer;

`ifdef WBUF_FORWARD_EN
  localparam bit c_FWD = 1'b1;
`else
  localparam bit c_FWD = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST;
  logic        PushValid;
  logic        PushReady;
  logic [4:0]  PushAddress;
  logic [31:0] PushData;
  logic        DrainEn;
  logic [4:0]  WriteAddress;
  logic [31:0] WriteData;
  logic        ReadWriteEn;
  logic [4:0]  FwdAddress1;
  logic [4:0]  FwdAddress2;
  logic        FwdHit1;
  logic        FwdHit2;
  logic [31:0] FwdData1;
  logic [31:0] FwdData2;
  logic [2:0]  Count;

  int vectors    = 0;
  int miscompares = 0;

  regfile_write_buffer #(.DATA_W(32), .ADDR_W(5), .DEPTH(4)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .PushValid    (PushValid),
    .PushReady    (PushReady),
    .PushAddress  (PushAddress),
    .PushData     (PushData),
    .DrainEn      (DrainEn),
    .WriteAddress (WriteAddress),
    .WriteData    (WriteData),
    .ReadWriteEn  (ReadWriteEn),
    .FwdAddress1  (FwdAddress1),
    .FwdAddress2  (FwdAddress2),
    .FwdHit1      (FwdHit1),
    .FwdHit2      (FwdHit2),
    .FwdData1     (FwdData1),
    .FwdData2     (FwdData2),
    .Count        (Count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  initial begin
    RST = 1'b1; PushValid = 1'b0; PushAddress = '0; PushData = '0;
    DrainEn = 1'b1; FwdAddress1 = '0; FwdAddress2 = '0;
    tick(); tick();
    RST = 1'b0;
    #1;
    chk("rst_ready", PushReady, 1);
    chk("rst_rwe", ReadWriteEn, 0);
    chk("rst_count", Count, 0);
    chk("rst_waddr", WriteAddress, 0);
    chk("rst_wdata", WriteData, 0);
    chk("rst_hit1", FwdHit1, 0);
    chk("rst_fdata1", FwdData1, 0);

    // single push R8 <- 5, drained the next cycle
    PushValid = 1'b1; PushAddress = 5'd8; PushData = 32'h5;
    #1;
    chk("push_empty_rwe", ReadWriteEn, 0);
    tick();
    PushValid = 1'b0; FwdAddress1 = 5'd8;
    #1;
    chk("p1_rwe", ReadWriteEn, 1);
    chk("p1_waddr", WriteAddress, 8);
    chk("p1_wdata", WriteData, 5);
    chk("p1_count", Count, 1);
    chk("p1_hit", FwdHit1, c_FWD);
    chk("p1_fdata", FwdData1, c_FWD ? 32'h5 : 32'h0);
    tick(); #1;
    chk("p1_count_after", Count, 0);
    chk("p1_rwe_after", ReadWriteEn, 0);

    // fill with R10 <- 1..4 while draining is blocked
    DrainEn = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      PushValid = 1'b1; PushAddress = 5'd10; PushData = 32'(i);
      tick();
    end
    PushData = 32'h5; FwdAddress1 = 5'd10; FwdAddress2 = 5'd3;
    #1;
    chk("full_ready", PushReady, 0);
    chk("full_count", Count, 4);
    chk("full_rwe", ReadWriteEn, 0);
    chk("full_hit1", FwdHit1, c_FWD);
    chk("full_fdata1", FwdData1, c_FWD ? 32'h4 : 32'h0);
    chk("full_hit2_miss", FwdHit2, 0);
    chk("full_fdata2_miss", FwdData2, 0);
    tick(); #1;
    chk("full_fifth_rejected", Count, 4);

    // drain with a pending fifth push
    DrainEn = 1'b1;
    #1;
    chk("d0_rwe", ReadWriteEn, 1);
    chk("d0_wdata", WriteData, 1);
    chk("d0_ready", PushReady, 0);
    tick(); #1;
    chk("d1_count", Count, 3);
    chk("d1_ready", PushReady, 1);
    chk("d1_wdata", WriteData, 2);
    chk("d1_fdata_nopush", FwdData1, c_FWD ? 32'h4 : 32'h0);
    tick();
    PushValid = 1'b0;
    #1;
    chk("d2_count", Count, 3);
    chk("d2_wdata", WriteData, 3);
    chk("d2_fdata_newest", FwdData1, c_FWD ? 32'h5 : 32'h0);
    tick(); #1;
    chk("d3_count", Count, 2);
    chk("d3_wdata", WriteData, 4);
    tick(); #1;
    chk("d4_count", Count, 1);
    chk("d4_wdata", WriteData, 5);
    chk("d4_waddr", WriteAddress, 10);
    tick(); #1;
    chk("d5_count", Count, 0);
    chk("d5_rwe", ReadWriteEn, 0);

    // write to R0 is accepted and dropped
    PushValid = 1'b1; PushAddress = 5'd0; PushData = 32'hFFFF_FFFF; FwdAddress2 = 5'd0;
    #1;
    chk("r0_ready", PushReady, 1);
    tick();
    PushValid = 1'b0;
    #1;
    chk("r0_count", Count, 0);
    chk("r0_rwe", ReadWriteEn, 0);
    chk("r0_hit2", FwdHit2, 0);
    chk("r0_wdata", WriteData, 0);

    // reset discards pending entries and wins over a same-cycle push
    DrainEn = 1'b0;
    PushValid = 1'b1; PushAddress = 5'd9;  PushData = 32'hA; tick();
    PushValid = 1'b1; PushAddress = 5'd11; PushData = 32'hB; tick();
    PushValid = 1'b0; FwdAddress1 = 5'd11;
    #1;
    chk("pre_rst_count", Count, 2);
    chk("pre_rst_hit1", FwdHit1, c_FWD);
    RST = 1'b1; PushValid = 1'b1; PushAddress = 5'd12; PushData = 32'hC; DrainEn = 1'b1;
    tick();
    RST = 1'b0; PushValid = 1'b0;
    #1;
    chk("mid_rst_count", Count, 0);
    chk("mid_rst_rwe", ReadWriteEn, 0);
    chk("mid_rst_hit1", FwdHit1, 0);
    chk("mid_rst_waddr", WriteAddress, 0);
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      chk("post_rst_rwe", ReadWriteEn, 0);
      chk("post_rst_no_r11", (WriteAddress == 5'd11), 0);
    end

    // pending R8 with lookups, then drained
    DrainEn = 1'b0;
    PushValid = 1'b1; PushAddress = 5'd8; PushData = 32'h77;
    tick();
    PushValid = 1'b0; FwdAddress1 = 5'd8;
    #1;
    chk("r8_count", Count, 1);
    chk("r8_hit1", FwdHit1, c_FWD);
    chk("r8_fdata1", FwdData1, c_FWD ? 32'h77 : 32'h0);
    DrainEn = 1'b1;
    #1;
    chk("r8_rwe", ReadWriteEn, 1);
    chk("r8_waddr", WriteAddress, 8);
    chk("r8_wdata", WriteData, 32'h77);
    chk("r8_hit_drain", FwdHit1, c_FWD);
    tick(); #1;
    chk("r8_count_after", Count, 0);
    chk("r8_rwe_after", ReadWriteEn, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
